// File: rtl/sec_keyed_decoder_if.sv
// Stream bundle for sec_keyed_decoder: input word handshake and
// corrected-output handshake with syndrome, status flags and error position.
interface sec_keyed_decoder_if #(
   parameter int DATA_W  = 32,
   parameter int CHECK_W = 8,
   parameter int POS_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1
);
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_data;
   logic [CHECK_W-1:0] in_check;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic [CHECK_W-1:0] out_syndrome;
   logic               err_corr;
   logic               err_check;
   logic               err_uncorr;
   logic [POS_W-1:0]   err_pos;

   modport master (
      output in_valid, in_data, in_check, out_ready,
      input  in_ready, out_valid, out_data, out_syndrome,
      input  err_corr, err_check, err_uncorr, err_pos
   );

   modport slave (
      input  in_valid, in_data, in_check, out_ready,
      output in_ready, out_valid, out_data, out_syndrome,
      output err_corr, err_check, err_uncorr, err_pos
   );
endinterface

// File: rtl/sec_keyed_decoder.sv
// Pipelined SEC decoder whose low NUM_LUTS syndrome XORs are key-programmed LUTs.
// Ports: clk, rst_n, key_bit/key_shift/key_clear -> key_armed, check_en, io (slave stream).
module sec_keyed_decoder #(
   parameter int DATA_W   = 32,
   parameter int CHECK_W  = 8,
   parameter int NUM_LUTS = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_bit,
   input  logic key_shift,
   input  logic key_clear,
   output logic key_armed,
   input  logic check_en,
   sec_keyed_decoder_if.slave io
);
   localparam int POS_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int KEY_W = 4 * NUM_LUTS;
   localparam int CNT_W = $clog2(KEY_W + 1);

   if (DATA_W > (1 << CHECK_W) - CHECK_W - 1) begin : g_bad_dw
      $error("DATA_W too large for CHECK_W");
   end
   if (NUM_LUTS < 1 || NUM_LUTS > CHECK_W) begin : g_bad_nl
      $error("NUM_LUTS out of range");
   end

   typedef logic [DATA_W-1:0][CHECK_W-1:0] hmat_t;

   // Columns are the ascending CHECK_W-bit values of weight >= 2,
   // so no column collides with zero or a single check-bit error.
   function automatic hmat_t gen_h();
      hmat_t h;
      int    j;
      int    ones;
      h = '0;
      j = 0;
      for (int v = 0; v < (1 << CHECK_W) && j < DATA_W; v++) begin
         ones = 0;
         for (int b = 0; b < CHECK_W; b++) begin
            ones += (v >> b) & 1;
         end
         if (ones >= 2) begin
            h[j] = CHECK_W'(v);
            j++;
         end
      end
      return h;
   endfunction

   localparam hmat_t H = gen_h();

   typedef enum logic [1:0] {
      EMPTY,
      LOAD,
      ARMED
   } kstate_t;

   kstate_t          state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         key_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      if (key_clear) begin
         state_d = EMPTY;
         key_d   = '0;
         cnt_d   = '0;
      end else if (key_shift) begin
         unique case (state_q)
            EMPTY, LOAD: begin
               key_d   = {key_q[KEY_W-2:0], key_bit};
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_d == CNT_W'(KEY_W)) ? ARMED : LOAD;
            end
            default: begin
            end
         endcase
      end
   end

   assign key_armed = (state_q == ARMED);

   logic [CHECK_W-1:0] par;
   logic [CHECK_W-1:0] chk;
   logic [CHECK_W-1:0] syn;
   logic [3:0]         nib;

   // Keyed bits index their nibble with {parity, check}; 4'b0110 is XOR.
   always_comb begin
      par = '0;
      nib = '0;
      for (int i = 0; i < CHECK_W; i++) begin
         for (int j = 0; j < DATA_W; j++) begin
            if (H[j][i]) begin
               par[i] = par[i] ^ io.in_data[j];
            end
         end
      end
      chk = io.in_check & {CHECK_W{check_en}};
      syn = par ^ chk;
      for (int i = 0; i < NUM_LUTS; i++) begin
         nib    = key_q[4*i +: 4];
         syn[i] = nib[{par[i], chk[i]}];
      end
   end

   logic               s1_valid;
   logic [DATA_W-1:0]  s1_data;
   logic [CHECK_W-1:0] s1_syn;
   logic               s1_load;
   logic               s2_load;

   assign s2_load     = !io.out_valid | io.out_ready;
   assign io.in_ready = key_armed & (!s1_valid | s2_load);
   assign s1_load     = io.in_valid & io.in_ready;

   // The key only shapes the stage-1 syndrome, so a later key_clear
   // cannot disturb words already captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_data  <= io.in_data;
         s1_syn   <= syn;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   logic [DATA_W-1:0] fix_data;
   logic [POS_W-1:0]  fix_pos;
   logic              hit;
   logic              fix_corr;
   logic              fix_chk;
   logic              fix_unc;

   always_comb begin
      fix_data = s1_data;
      fix_pos  = '0;
      hit      = 1'b0;
      fix_corr = 1'b0;
      fix_chk  = 1'b0;
      fix_unc  = 1'b0;
      for (int j = 0; j < DATA_W; j++) begin
         if (s1_syn == H[j]) begin
            hit         = 1'b1;
            fix_pos     = POS_W'(j);
            fix_data[j] = ~s1_data[j];
         end
      end
      unique case (1'b1)
         (s1_syn == '0): begin
         end
         hit: begin
            fix_corr = 1'b1;
         end
         $onehot(s1_syn): begin
            fix_chk = 1'b1;
         end
         default: begin
            fix_unc = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io.out_valid    <= 1'b0;
         io.out_data     <= '0;
         io.out_syndrome <= '0;
         io.err_corr     <= 1'b0;
         io.err_check    <= 1'b0;
         io.err_uncorr   <= 1'b0;
         io.err_pos      <= '0;
      end else if (s2_load) begin
         io.out_valid <= s1_valid;
         if (s1_valid) begin
            io.out_data     <= fix_data;
            io.out_syndrome <= s1_syn;
            io.err_corr     <= fix_corr;
            io.err_check    <= fix_chk;
            io.err_uncorr   <= fix_unc;
            io.err_pos      <= fix_pos;
         end
      end
   end
endmodule

// File: tb/tb_sec_keyed_decoder.sv
// Self-checking bench for sec_keyed_decoder: directed key/decode cases plus
// randomized streams scored against a column-XOR reference model.
module tb_sec_keyed_decoder;
   localparam int DATA_W   = 32;
   localparam int CHECK_W  = 8;
   localparam int NUM_LUTS = 2;
   localparam int TMO      = 20;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  syn;
      logic        corr;
      logic        chk;
      logic        unc;
      logic [4:0]  pos;
   } res_t;

   logic clk       = 1'b0;
   logic rst_n     = 1'b0;
   logic key_bit   = 1'b0;
   logic key_shift = 1'b0;
   logic key_clear = 1'b0;
   logic check_en  = 1'b0;
   logic key_armed;

   sec_keyed_decoder_if #(.DATA_W(DATA_W), .CHECK_W(CHECK_W)) io ();

   sec_keyed_decoder #(
      .DATA_W(DATA_W),
      .CHECK_W(CHECK_W),
      .NUM_LUTS(NUM_LUTS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_bit(key_bit),
      .key_shift(key_shift),
      .key_clear(key_clear),
      .key_armed(key_armed),
      .check_en(check_en),
      .io(io)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  hcol [DATA_W];
   logic [7:0]  tb_key = '0;

   function automatic string fmt(res_t r);
      return $sformatf("data=%h syn=%h corr=%b chk=%b unc=%b pos=%0d",
                       r.data, r.syn, r.corr, r.chk, r.unc, r.pos);
   endfunction

   function automatic res_t observe();
      return {io.out_data, io.out_syndrome, io.err_corr,
              io.err_check, io.err_uncorr, io.err_pos};
   endfunction

   // Reference: syndrome is the XOR of the columns of set data bits,
   // check term added, then keyed bits looked up in their key nibble.
   function automatic res_t model(logic [31:0] d, logic [7:0] c,
                                  logic ce, logic [7:0] key);
      res_t       r;
      logic [7:0] p;
      logic [7:0] cc;
      logic [7:0] s;
      logic [3:0] nib;
      int         k;
      p = '0;
      for (int j = 0; j < DATA_W; j++) if (d[j]) p = p ^ hcol[j];
      cc = ce ? c : 8'h00;
      s  = p ^ cc;
      for (int i = 0; i < NUM_LUTS; i++) begin
         nib  = 4'(key >> (4 * i));
         s[i] = nib[{p[i], cc[i]}];
      end
      r      = '0;
      r.data = d;
      r.syn  = s;
      k      = -1;
      for (int j = 0; j < DATA_W; j++) if (hcol[j] == s) k = j;
      if (s == 8'h00) begin
      end else if (k >= 0) begin
         r.corr    = 1'b1;
         r.pos     = 5'(k);
         r.data[k] = ~d[k];
      end else if ($countones(s) == 1) begin
         r.chk = 1'b1;
      end else begin
         r.unc = 1'b1;
      end
      return r;
   endfunction

   task automatic build_h();
      int n;
      n = 0;
      for (int v = 1; v < 256 && n < DATA_W; v++) begin
         if ($countones(8'(v)) >= 2) begin
            hcol[n] = 8'(v);
            n++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [7:0] k);
      for (int b = 7; b >= 0; b--) begin
         key_shift = 1'b1;
         key_bit   = k[b];
         tick();
      end
      key_shift = 1'b0;
      key_bit   = 1'b0;
      tb_key    = k;
   endtask

   task automatic clear_key();
      key_clear = 1'b1;
      tick();
      key_clear = 1'b0;
   endtask

   task automatic xfer(input logic [31:0] d, input logic [7:0] c,
                       input logic ce, output res_t r, output int lat);
      int n;
      io.out_ready = 1'b1;
      io.in_data   = d;
      io.in_check  = c;
      check_en     = ce;
      io.in_valid  = 1'b1;
      #1;
      n = 0;
      while (!io.in_ready && n < TMO) begin
         tick();
         n++;
      end
      @(posedge clk);
      #1;
      io.in_valid = 1'b0;
      lat = 1;
      while (!io.out_valid && lat < TMO) begin
         tick();
         lat++;
      end
      r = io.out_valid ? observe() : '1;
      tick();
   endtask

   task automatic gen_word(output logic [31:0] d, output logic [7:0] c,
                           output logic ce);
      res_t b;
      int   k;
      d  = $urandom;
      ce = ($urandom_range(0, 7) != 0);
      b  = model(d, 8'h00, 1'b1, 8'h66);
      c  = b.syn;
      case ($urandom_range(0, 4))
         1: begin
            k = $urandom_range(0, 31);
            d[k] = ~d[k];
         end
         2: begin
            k = $urandom_range(0, 7);
            c[k] = ~c[k];
         end
         3: begin
            k = $urandom_range(0, 31);
            d[k] = ~d[k];
            k = $urandom_range(0, 31);
            d[k] = ~d[k];
         end
         4: c = 8'($urandom);
         default: begin
         end
      endcase
   endtask

   task automatic test_reset();
      res_t o;
      #1;
      o = observe();
      checks++;
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b0 || key_armed !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: out_valid=%b in_ready=%b key_armed=%b, want 0 0 0",
                  io.out_valid, io.in_ready, key_armed);
      end
      checks++;
      if (o !== '0) begin
         errors++;
         $display("FAIL reset_out: %s, want all zero", fmt(o));
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_key_load();
      logic [7:0] k;
      k = 8'h66;
      for (int i = 0; i < 8; i++) begin
         key_shift = 1'b1;
         key_bit   = k[7-i];
         tick();
         checks++;
         if (key_armed !== (i == 7)) begin
            errors++;
            $display("FAIL key_armed_pulse%0d: got %b want %b", i + 1, key_armed, i == 7);
         end
      end
      key_bit = 1'b1;
      tick();
      key_shift = 1'b0;
      key_bit   = 1'b0;
      tb_key    = 8'h66;
      checks++;
      if (key_armed !== 1'b1) begin
         errors++;
         $display("FAIL key_armed_extra: got %b want 1", key_armed);
      end
   endtask

   task automatic test_single_error();
      res_t r;
      res_t e;
      int   lat;
      xfer(32'h0000_0004, 8'h00, 1'b1, r, lat);
      e = '{data: 32'h0, syn: 8'h06, corr: 1'b1, chk: 1'b0, unc: 1'b0, pos: 5'd2};
      checks++;
      if (r !== e) begin
         errors++;
         $display("FAIL single_err: got %s want %s", fmt(r), fmt(e));
      end
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL single_err_latency: got %0d want 2", lat);
      end
   endtask

   task automatic test_check_error();
      res_t r;
      res_t e;
      int   lat;
      xfer(32'h0, 8'h10, 1'b1, r, lat);
      e = '{data: 32'h0, syn: 8'h10, corr: 1'b0, chk: 1'b1, unc: 1'b0, pos: 5'd0};
      checks++;
      if (r !== e) begin
         errors++;
         $display("FAIL check_err: got %s want %s", fmt(r), fmt(e));
      end
      xfer(32'h0, 8'h10, 1'b0, r, lat);
      e = '0;
      checks++;
      if (r !== e) begin
         errors++;
         $display("FAIL check_en_off: got %s want %s", fmt(r), fmt(e));
      end
   endtask

   task automatic test_uncorr();
      res_t r;
      res_t e;
      int   lat;
      xfer(32'h0, 8'h30, 1'b1, r, lat);
      e = '{data: 32'h0, syn: 8'h30, corr: 1'b0, chk: 1'b0, unc: 1'b1, pos: 5'd0};
      checks++;
      if (r !== e) begin
         errors++;
         $display("FAIL uncorr: got %s want %s", fmt(r), fmt(e));
      end
   endtask

   task automatic test_wrong_key();
      res_t r;
      res_t e;
      int   lat;
      clear_key();
      checks++;
      if (key_armed !== 1'b0 || io.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL clear_key: key_armed=%b in_ready=%b want 0 0", key_armed, io.in_ready);
      end
      load_key(8'h00);
      xfer(32'h0000_0004, 8'h00, 1'b1, r, lat);
      e = '{data: 32'h4, syn: 8'h04, corr: 1'b0, chk: 1'b1, unc: 1'b0, pos: 5'd0};
      checks++;
      if (r !== e) begin
         errors++;
         $display("FAIL wrong_key: got %s want %s", fmt(r), fmt(e));
      end
      clear_key();
      load_key(8'h06);
      xfer(32'h0000_0001, 8'h00, 1'b1, r, lat);
      e = '{data: 32'h1, syn: 8'h01, corr: 1'b0, chk: 1'b1, unc: 1'b0, pos: 5'd0};
      checks++;
      if (r !== e) begin
         errors++;
         $display("FAIL half_key: got %s want %s", fmt(r), fmt(e));
      end
      clear_key();
      load_key(8'h66);
   endtask

   task automatic test_random_key();
      res_t        r;
      res_t        e;
      int          lat;
      logic [31:0] d;
      logic [7:0]  c;
      logic        ce;
      for (int n = 0; n < 4; n++) begin
         clear_key();
         load_key(8'($urandom));
         for (int w = 0; w < 4; w++) begin
            gen_word(d, c, ce);
            xfer(d, c, ce, r, lat);
            e = model(d, c, ce, tb_key);
            checks++;
            if (r !== e) begin
               errors++;
               $display("FAIL random_key k=%h: got %s want %s", tb_key, fmt(r), fmt(e));
            end
         end
      end
      clear_key();
      load_key(8'h66);
   endtask

   task automatic test_random_stream();
      res_t        q[$];
      res_t        o;
      logic [31:0] pd;
      logic [7:0]  pc;
      logic        pce;
      bit          pend;
      pend = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         io.out_ready = ($urandom_range(0, 3) != 0);
         if (!pend && $urandom_range(0, 4) != 0) begin
            gen_word(pd, pc, pce);
            pend = 1'b1;
         end
         io.in_valid = pend;
         io.in_data  = pd;
         io.in_check = pc;
         check_en    = pce;
         #1;
         if (io.in_valid && io.in_ready) begin
            q.push_back(model(pd, pc, pce, tb_key));
            pend = 1'b0;
         end
         if (io.out_valid) begin
            o = observe();
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL stream_extra: unexpected %s", fmt(o));
            end else if (o !== q[0]) begin
               errors++;
               $display("FAIL stream_word: got %s want %s", fmt(o), fmt(q[0]));
            end
            if (io.out_ready && q.size() != 0) void'(q.pop_front());
         end
         @(posedge clk);
         #1;
      end
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      for (int cyc = 0; cyc < TMO && q.size() != 0; cyc++) begin
         #1;
         if (io.out_valid) begin
            o = observe();
            checks++;
            if (o !== q[0]) begin
               errors++;
               $display("FAIL stream_drain: got %s want %s", fmt(o), fmt(q[0]));
            end
            void'(q.pop_front());
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL stream_lost: %0d words never came out, want 0", q.size());
      end
   endtask

   task automatic test_back_to_back();
      res_t        q[$];
      res_t        o;
      logic [31:0] wd [4];
      logic [7:0]  wc [4];
      logic        wce;
      int          sent;
      int          got;
      for (int i = 0; i < 4; i++) gen_word(wd[i], wc[i], wce);
      sent = 0;
      got  = 0;
      check_en = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         key_clear    = 1'b0;
         io.out_ready = !(cyc >= 2 && cyc <= 4);
         io.in_valid  = (sent < 4);
         io.in_data   = wd[sent % 4];
         io.in_check  = wc[sent % 4];
         #1;
         if (cyc == 3) begin
            checks++;
            if (io.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_stall_ready: got %b want 0", io.in_ready);
            end
         end
         if (io.in_valid && io.in_ready) begin
            q.push_back(model(wd[sent], wc[sent], 1'b1, tb_key));
            sent++;
            if (sent == 4) key_clear = 1'b1;
         end
         if (io.out_valid) begin
            o = observe();
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra: unexpected %s", fmt(o));
            end else if (o !== q[0]) begin
               errors++;
               $display("FAIL bp_word%0d: got %s want %s", got, fmt(o), fmt(q[0]));
            end
            if (io.out_ready && q.size() != 0) begin
               void'(q.pop_front());
               got++;
            end
         end
         @(posedge clk);
         #1;
      end
      key_clear   = 1'b0;
      io.in_valid = 1'b0;
      checks++;
      if (got != 4 || sent != 4) begin
         errors++;
         $display("FAIL bp_count: sent=%0d got=%0d want 4 4", sent, got);
      end
      checks++;
      if (io.in_ready !== 1'b0 || key_armed !== 1'b0) begin
         errors++;
         $display("FAIL bp_after_clear: in_ready=%b key_armed=%b want 0 0",
                  io.in_ready, key_armed);
      end
      load_key(8'h66);
   endtask

   task automatic test_reset_mid();
      res_t o;
      io.out_ready = 1'b0;
      io.in_data   = 32'h0000_0004;
      io.in_check  = 8'h00;
      check_en     = 1'b1;
      io.in_valid  = 1'b1;
      tick();
      io.in_valid = 1'b0;
      tick();
      checks++;
      if (io.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: out_valid=%b want 1", io.out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      o = observe();
      checks++;
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b0 || key_armed !== 1'b0 || o !== '0) begin
         errors++;
         $display("FAIL mid_reset: out_valid=%b in_ready=%b key_armed=%b %s want all 0",
                  io.out_valid, io.in_ready, key_armed, fmt(o));
      end
      tick();
      @(negedge clk);
      rst_n        = 1'b1;
      io.out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (io.out_valid !== 1'b0 || key_armed !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: out_valid=%b key_armed=%b want 0 0",
                  io.out_valid, key_armed);
      end
   endtask

   initial begin
      io.in_valid  = 1'b0;
      io.in_data   = '0;
      io.in_check  = '0;
      io.out_ready = 1'b0;
      build_h();
      test_reset();
      test_key_load();
      test_single_error();
      test_check_error();
      test_uncorr();
      test_wrong_key();
      test_random_key();
      test_random_stream();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
